// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: joystick X from a 5-byte packet sets the pulse width,
// slewed once per frame, with a centre deadband and centre-request bit.
module servo_pwm_gen #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned PERIOD_US = 20000,
    parameter int unsigned MIN_US    = 1000,
    parameter int unsigned MAX_US    = 2000,
    parameter int unsigned DEADBAND  = 16,
    parameter int unsigned SLEW_US   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] din,
    output logic        pwm,
    output logic [11:0] width_us,
    output logic        active
);

    localparam int unsigned DIV   = (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CNT_W = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;

    localparam logic [11:0] MID_W  = 12'((MIN_US + MAX_US) / 2);
    localparam logic [11:0] SLEW_W = 12'(SLEW_US);
    localparam logic [41:0] MIN42  = 42'(MIN_US);
    localparam logic [41:0] MAX42  = 42'(MAX_US);
    localparam logic [41:0] SPAN42 = 42'(MAX_US - MIN_US);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [PRE_W-1:0]   pre_cnt;
    logic [CNT_W-1:0]   us_cnt;
    logic [CNT_W-1:0]   us_cnt_next;
    logic               us_tick;
    logic               frame_start;
    logic [39:0]        din_r;
    logic [11:0]        target_us;
    logic [11:0]        target_next;
    logic [11:0]        width_next;
    logic [11:0]        diff;
    logic               armed;
    logic               armed_next;
    logic [9:0]         x;
    logic [9:0]         x_dist;
    logic [9:0]         x_eff;
    logic [41:0]        prod;
    logic [41:0]        tgt;

    always_comb begin
        us_tick     = (pre_cnt == PRE_W'(DIV - 1));
        frame_start = us_tick && (us_cnt == CNT_W'(PERIOD_US - 1));
    end

    always_comb begin
        x      = {din_r[25:24], din_r[39:32]};
        x_dist = (x >= 10'd512) ? x - 10'd512 : 10'd512 - x;
        x_eff  = (din_r[0] || (32'(x_dist) < DEADBAND)) ? 10'd512 : x;
        prod   = 42'(x_eff) * SPAN42;
        tgt    = MIN42 + (prod >> 10);
        if (tgt < MIN42) begin
            tgt = MIN42;
        end else if (tgt > MAX42) begin
            tgt = MAX42;
        end
        target_next = tgt[11:0];
    end

    // Width and arming are only touched on a RUN frame start, so a pulse in
    // progress never sees a new target and the first pulse is frame-aligned.
    always_comb begin
        us_cnt_next = us_cnt;
        width_next  = width_us;
        armed_next  = armed;
        diff        = '0;
        if (us_tick) begin
            us_cnt_next = frame_start ? '0 : us_cnt + 1'b1;
        end
        if (frame_start && state == RUN) begin
            armed_next = 1'b1;
            if (target_us > width_us) begin
                diff       = target_us - width_us;
                width_next = width_us + ((diff > SLEW_W) ? SLEW_W : diff);
            end else if (target_us < width_us) begin
                diff       = width_us - target_us;
                width_next = width_us - ((diff > SLEW_W) ? SLEW_W : diff);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pre_cnt   <= '0;
            us_cnt    <= '0;
            din_r     <= '0;
            target_us <= '0;
            width_us  <= MID_W;
            armed     <= 1'b0;
            pwm       <= 1'b0;
            active    <= 1'b0;
        end else begin
            pre_cnt   <= us_tick ? '0 : pre_cnt + 1'b1;
            us_cnt    <= us_cnt_next;
            din_r     <= din;
            target_us <= target_next;
            width_us  <= width_next;
            armed     <= armed_next;
            pwm       <= armed_next && (32'(us_cnt_next) < 32'(width_next));
            case (state)
                IDLE: begin
                    if (din_r != '0) begin
                        state  <= RUN;
                        active <= 1'b1;
                    end
                end
                RUN: begin
                    state  <= RUN;
                    active <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule
